// File: rtl/weight_fetch_sequencer.sv
// weight_fetch_sequencer
//
// Loads one R x S filter of 8-bit weights from memory into the PE array,
// one PE row at a time. Weights are packed four to a 32-bit word, little
// endian, starting at the word-aligned filter base address. Each fetched
// word is unpacked one byte per cycle into a row assembler. When a row is
// complete it is presented to the PE array for one cycle on the row-write
// strobe.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   start               begin a fetch (sampled only while idle)
//   param_R, param_S    filter height / width, sampled with start
//   weight_base_addr    filter byte base address (bits [1:0] ignored)
//   rd_req, rd_addr     word read request / word-aligned address
//   rd_gnt              request accepted this cycle
//   rd_valid, rd_data   read data return
//   weight_row_wr_en    one-cycle row write strobe
//   weight_row_wr_ctrl  row index being written
//   weight_row_data     row data, column c at bits [8c+7:8c]
//   busy, done, err     status: not idle / completion pulse / sticky bad params
module weight_fetch_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int PE_ROWS    = 5,
  parameter int PE_COLS    = 5
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    start,
  input  logic [3:0]              param_R,
  input  logic [3:0]              param_S,
  input  logic [ADDR_WIDTH-1:0]   weight_base_addr,
  output logic                    rd_req,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    rd_gnt,
  input  logic                    rd_valid,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    weight_row_wr_en,
  output logic [2:0]              weight_row_wr_ctrl,
  output logic [8*PE_COLS-1:0]    weight_row_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_UNPACK = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

  logic [2:0]              state_reg;
  logic [ADDR_WIDTH-1:0]   base_reg;
  logic [3:0]              word_idx_reg;
  logic [7:0]              n_reg;         // total weights R*S
  logic [7:0]              cnt_reg;       // weights consumed so far
  logic [1:0]              byte_sel_reg;  // byte lane within the current word
  logic [3:0]              s_reg;
  logic [3:0]              col_reg;
  logic [2:0]              row_idx_reg;
  logic [DATA_WIDTH-1:0]   word_buf_reg;
  logic [8*PE_COLS-1:0]    row_buf_reg;
  logic                    wr_en_reg;
  logic [2:0]              wr_ctrl_reg;
  logic [8*PE_COLS-1:0]    wr_data_reg;
  logic                    err_reg;

  logic                    params_ok;
  logic [7:0]              cur_byte;
  logic [7:0]              word_bytes [BYTES_PER_WORD];
  logic [8*PE_COLS-1:0]    row_with_byte;

  assign params_ok = (param_R != 4'd0) && (param_S != 4'd0) &&
                     (int'(param_R) <= PE_ROWS) && (int'(param_S) <= PE_COLS);

  // Split the buffered word into byte lanes for the unpack mux.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign word_bytes[gi] = word_buf_reg[8*gi +: 8];
    end
  endgenerate

  assign cur_byte = word_bytes[byte_sel_reg];

  // Row buffer with the byte being consumed this cycle dropped into its
  // column; this is what gets written when the row completes.
  generate
    for (gi = 0; gi < PE_COLS; gi++) begin : g_col
      assign row_with_byte[8*gi +: 8] = (col_reg == 4'(gi)) ? cur_byte
                                                            : row_buf_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= S_IDLE;
      base_reg     <= '0;
      word_idx_reg <= '0;
      n_reg        <= '0;
      cnt_reg      <= '0;
      byte_sel_reg <= '0;
      s_reg        <= '0;
      col_reg      <= '0;
      row_idx_reg  <= '0;
      word_buf_reg <= '0;
      row_buf_reg  <= '0;
      wr_en_reg    <= 1'b0;
      wr_ctrl_reg  <= '0;
      wr_data_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (params_ok) begin
              err_reg      <= 1'b0;
              base_reg     <= weight_base_addr & ~ADDR_WIDTH'(3);
              n_reg        <= {4'd0, param_R} * {4'd0, param_S};
              s_reg        <= param_S;
              word_idx_reg <= '0;
              cnt_reg      <= '0;
              byte_sel_reg <= '0;
              col_reg      <= '0;
              row_idx_reg  <= '0;
              row_buf_reg  <= '0;
              state_reg    <= S_FETCH;
            end else begin
              // Illegal shape: report straight away without touching memory.
              err_reg   <= 1'b1;
              state_reg <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          if (rd_gnt) state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (rd_valid) begin
            word_buf_reg <= rd_data;
            byte_sel_reg <= '0;
            state_reg    <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          cnt_reg      <= cnt_reg + 8'd1;
          byte_sel_reg <= byte_sel_reg + 2'd1;
          if (col_reg == s_reg - 4'd1) begin
            wr_en_reg   <= 1'b1;
            wr_ctrl_reg <= row_idx_reg;
            wr_data_reg <= row_with_byte;
            row_buf_reg <= '0;
            col_reg     <= '0;
            row_idx_reg <= row_idx_reg + 3'd1;
          end else begin
            row_buf_reg <= row_with_byte;
            col_reg     <= col_reg + 4'd1;
          end
          // The total count, not the lane, decides completion, so the final
          // word stops after only its valid bytes.
          if (cnt_reg + 8'd1 == n_reg) begin
            state_reg <= S_DONE;
          end else if (byte_sel_reg == 2'(BYTES_PER_WORD - 1)) begin
            word_idx_reg <= word_idx_reg + 4'd1;
            state_reg    <= S_FETCH;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign rd_req             = (state_reg == S_FETCH);
  assign rd_addr            = base_reg + (ADDR_WIDTH'(word_idx_reg) << 2);
  assign weight_row_wr_en   = wr_en_reg;
  assign weight_row_wr_ctrl = wr_ctrl_reg;
  assign weight_row_data    = wr_data_reg;
  assign busy               = (state_reg != S_IDLE);
  assign done               = (state_reg == S_DONE);
  assign err                = err_reg;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Testbench for weight_fetch_sequencer. Stimulus pushes the expected reads,
// row writes and completions (with their cycle numbers) into queues; a
// monitor on the falling edge pops and compares whenever the DUT presents
// one. Memory byte at address A holds A[7:0].
module tb_weight_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [3:0]  param_R, param_S;
  logic [31:0] weight_base_addr;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_gnt, rd_valid;
  logic [31:0] rd_data;
  logic        weight_row_wr_en;
  logic [2:0]  weight_row_wr_ctrl;
  logic [39:0] weight_row_data;
  logic        busy, done, err;

  weight_fetch_sequencer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .PE_ROWS(5), .PE_COLS(5)
  ) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .param_R(param_R), .param_S(param_S),
    .weight_base_addr(weight_base_addr), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .weight_row_wr_en(weight_row_wr_en), .weight_row_wr_ctrl(weight_row_wr_ctrl),
    .weight_row_data(weight_row_data), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int c; logic [31:0] a; } rd_exp_t;
  typedef struct { int c; logic [2:0] row; logic [39:0] data; } row_exp_t;
  typedef struct { int c; logic e; } done_exp_t;

  rd_exp_t   exp_rd   [$];
  row_exp_t  exp_row  [$];
  done_exp_t exp_done [$];

  int checks = 0;
  int fails  = 0;
  int t0     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_rd(input int rel, input logic [31:0] a);
    rd_exp_t e;
    e.c = t0 + rel; e.a = a;
    exp_rd.push_back(e);
  endtask

  task automatic push_row(input int rel, input logic [2:0] r, input logic [39:0] d);
    row_exp_t e;
    e.c = t0 + rel; e.row = r; e.data = d;
    exp_row.push_back(e);
  endtask

  task automatic push_done(input int rel, input logic e_v);
    done_exp_t e;
    e.c = t0 + rel; e.e = e_v;
    exp_done.push_back(e);
  endtask

  // ---------------- memory responder ----------------
  int   stall_at   = -1;
  int   stall_len  = 0;
  int   stall_left = 0;
  int   gnt_count  = 0;
  logic pend       = 1'b0;
  logic force_valid = 1'b0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {8'(b + 8'd3), 8'(b + 8'd2), 8'(b + 8'd1), b};
  endfunction

  initial begin
    rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(posedge CLK); #2;
      rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
      if (pend) begin
        rd_valid = 1'b1; rd_data = word_at(pend_addr); pend = 1'b0;
      end else if (force_valid) begin
        rd_valid = 1'b1; rd_data = 32'hDEADBEEF;
      end
      if (rd_req === 1'b1) begin
        if (gnt_count == stall_at && stall_left < stall_len) begin
          stall_left++;
        end else begin
          rd_gnt = 1'b1; pend = 1'b1; pend_addr = rd_addr;
          gnt_count++; stall_left = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic        mon_en = 1'b0;
  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [2:0]  last_row = '0;
  logic [39:0] last_data = '0;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (prev_pending) begin
        check("rd_req held", {63'd0, rd_req}, 64'd1);
        check("rd_addr held", {32'd0, rd_addr}, {32'd0, prev_addr});
      end
      prev_pending = rd_req && !rd_gnt;
      prev_addr    = rd_addr;

      if (rd_req && rd_gnt) begin
        if (exp_rd.size() == 0) begin
          check("unexpected read addr", {32'd0, rd_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          rd_exp_t e;
          e = exp_rd.pop_front();
          check("read addr", {32'd0, rd_addr}, {32'd0, e.a});
          check("read cycle", 64'(cyc), 64'(e.c));
        end
      end

      if (weight_row_wr_en) begin
        if (exp_row.size() == 0) begin
          check("unexpected row write", {61'd0, weight_row_wr_ctrl}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          row_exp_t e;
          e = exp_row.pop_front();
          check("row index", {61'd0, weight_row_wr_ctrl}, {61'd0, e.row});
          check("row data", {24'd0, weight_row_data}, {24'd0, e.data});
          check("row cycle", 64'(cyc), 64'(e.c));
          last_row  = e.row;
          last_data = e.data;
        end
      end else begin
        check("row index hold", {61'd0, weight_row_wr_ctrl}, {61'd0, last_row});
        check("row data hold", {24'd0, weight_row_data}, {24'd0, last_data});
      end

      if (done) begin
        if (exp_done.size() == 0) begin
          check("unexpected done", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          done_exp_t e;
          e = exp_done.pop_front();
          check("done cycle", 64'(cyc), 64'(e.c));
          check("err at done", {63'd0, err}, {63'd0, e.e});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic do_start(input logic [3:0] r, input logic [3:0] s, input logic [31:0] b);
    param_R = r; param_S = s; weight_base_addr = b; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin tick(1); n++; end
    check("fetch finished in budget", {63'd0, busy}, 64'd0);
    tick(2);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {24'd0, rd_req, rd_addr, weight_row_wr_en, weight_row_wr_ctrl, busy, done, err},
          64'd0);
    check({name, " row data"}, {24'd0, weight_row_data}, 64'd0);
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; param_R = '0; param_S = '0; weight_base_addr = '0;
    tick(3);
    check_all_zero("reset outputs");
    RESET = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // R=3 S=3 base 0x100, ideal memory
    t0 = cyc;
    push_rd(1, 32'h100); push_rd(7, 32'h104); push_rd(13, 32'h108);
    push_row(6, 3'd0, 40'h00_0002_0100);
    push_row(11, 3'd1, 40'h00_0005_0403);
    push_row(16, 3'd2, 40'h00_0008_0706);
    push_done(16, 1'b0);
    do_start(4'd3, 4'd3, 32'h100);
    check("busy after start", {63'd0, busy}, 64'd1);
    check("rd_req after start", {63'd0, rd_req}, 64'd1);
    wait_idle(100);

    // R=5 S=5 base 0x203 (low bits ignored)
    t0 = cyc;
    for (int w = 0; w < 7; w++) push_rd(1 + 6*w, 32'h200 + 32'(4*w));
    push_row(10, 3'd0, 40'h04_0302_0100);
    push_row(17, 3'd1, 40'h09_0807_0605);
    push_row(24, 3'd2, 40'h0E_0D0C_0B0A);
    push_row(31, 3'd3, 40'h13_1211_100F);
    push_row(40, 3'd4, 40'h18_1716_1514);
    push_done(40, 1'b0);
    do_start(4'd5, 4'd5, 32'h203);
    wait_idle(100);

    // R=1 S=1 base 0x3A4
    t0 = cyc;
    push_rd(1, 32'h3A4);
    push_row(4, 3'd0, 40'h00_0000_00A4);
    push_done(4, 1'b0);
    do_start(4'd1, 4'd1, 32'h3A4);
    wait_idle(50);

    // Illegal R=6 S=3: no read, done+err in cycle 1, err sticky
    t0 = cyc;
    push_done(1, 1'b1);
    do_start(4'd6, 4'd3, 32'h500);
    check("illegal busy", {63'd0, busy}, 64'd1);
    check("illegal no rd_req", {63'd0, rd_req}, 64'd0);
    check("illegal err", {63'd0, err}, 64'd1);
    wait_idle(20);
    tick(3);
    check("err sticky", {63'd0, err}, 64'd1);

    // R=2 S=2 base 0x40 clears err
    t0 = cyc;
    push_rd(1, 32'h40);
    push_row(5, 3'd0, 40'h00_0000_4140);
    push_row(7, 3'd1, 40'h00_0000_4342);
    push_done(7, 1'b0);
    do_start(4'd2, 4'd2, 32'h40);
    check("err cleared", {63'd0, err}, 64'd0);
    wait_idle(50);

    // R=3 S=3 with 3-cycle grant stall on the second read
    t0 = cyc;
    gnt_count = 0; stall_at = 1; stall_len = 3;
    push_rd(1, 32'h100); push_rd(10, 32'h104); push_rd(16, 32'h108);
    push_row(6, 3'd0, 40'h00_0002_0100);
    push_row(14, 3'd1, 40'h00_0005_0403);
    push_row(19, 3'd2, 40'h00_0008_0706);
    push_done(19, 1'b0);
    do_start(4'd3, 4'd3, 32'h100);
    wait_idle(100);
    stall_at = -1;

    // Reset during UNPACK of word 1
    t0 = cyc;
    push_rd(1, 32'h100); push_rd(7, 32'h104);
    push_row(6, 3'd0, 40'h00_0002_0100);
    do_start(4'd3, 4'd3, 32'h100);
    tick(9);
    RESET = 1'b1;
    tick(1);
    last_row = '0; last_data = '0;
    RESET = 1'b0;
    check_all_zero("mid-op reset outputs");
    tick(2);
    check("no request after reset", {63'd0, rd_req}, 64'd0);

    // Restart with a stray rd_valid present; a start while busy is ignored
    t0 = cyc;
    push_rd(1, 32'h80);
    push_row(5, 3'd0, 40'h00_0000_8180);
    push_row(7, 3'd1, 40'h00_0000_8382);
    push_done(7, 1'b0);
    force_valid = 1'b1;
    do_start(4'd2, 4'd2, 32'h80);
    tick(1);
    force_valid = 1'b0;
    do_start(4'd1, 4'd1, 32'h300);
    wait_idle(50);
    tick(5);

    check("reads left over", 64'(exp_rd.size()), 64'd0);
    check("rows left over", 64'(exp_row.size()), 64'd0);
    check("dones left over", 64'(exp_done.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
